core_bus_ctrl: RTL and testbench
================================

# core_bus_ctrl

External bus controller for the EMC08 core. Sits directly downstream of core_mem_ctrl: it accepts that block's active-low external ROM-read, RAM-read and RAM-write strobes with a 16-bit address and 8-bit write data. It runs a multiplexed 8051-style external bus cycle (ALE, PSEN_b, RD_b, WR_b, muxed P0, high address on P2) and returns read data and a completion pulse. It also synchronizes the EA_b pin for core_mem_ctrl.

## Interface
Parameters:
- WAIT_STATES, 0: extra strobe cycles per access, range 0..7.

Ports:
- bus_ctrl_clk_i  in  1  core clock.
- bus_ctrl_rst_b_i  in  1  asynchronous reset, active low.
- bus_ctrl_ext_rom_rd_b_i  in  1  external ROM read request, active low, from core_mem_ctrl.
- bus_ctrl_ext_ram_rd_b_i  in  1  external RAM read request, active low.
- bus_ctrl_ext_ram_wr_b_i  in  1  external RAM write request, active low.
- bus_ctrl_addr_i  in  16  access address.
- bus_ctrl_data_i  in  8  write data.
- bus_ctrl_data_o  out  8  read data returned to core_mem_ctrl.
- bus_ctrl_done_o  out  1  one-cycle access-complete pulse.
- bus_ctrl_busy_o  out  1  high from acceptance through END.
- bus_ctrl_ea_b_pin_i  in  1  raw EA_b pin.
- bus_ctrl_ea_b_o  out  1  synchronized EA_b, routed to core_mem_ctrl.
- bus_ctrl_ale_o  out  1  address latch enable.
- bus_ctrl_psen_b_o, bus_ctrl_rd_b_o, bus_ctrl_wr_b_o  out  1 each  external strobes, active low.
- bus_ctrl_p0_o  out  8  muxed address-low/data out.
- bus_ctrl_p0_i  in  8  P0 pad input.
- bus_ctrl_p0_oe_o  out  1  P0 output enable.
- bus_ctrl_p2_o  out  8  address high.

## Operation
- FSM states are IDLE, ADDR, LATCH, STROBE, END. All pin outputs are registered.
- IDLE:
  - Samples the requests. Priority is ROM read > RAM write > RAM read.
  - Captures the address, the write data and the access type.
- ADDR:
  - ale=1, p0_o=addr[7:0], p0_oe=1, p2_o=addr[15:8].
- LATCH:
  - ale=0 and p2 is held.
  - Write: p0_o=write data, p0_oe=1.
  - Read: p0_oe=0.
- STROBE:
  - The selected strobe is low: psen_b for ROM, rd_b for RAM read, wr_b for RAM write.
  - Lasts 1+WAIT_STATES cycles, counted by a 3-bit counter.
- END:
  - All strobes are high and done_o=1.
  - For reads, data_o holds the P0 value sampled on the edge that leaves STROBE.
  - For writes, P0 data and oe are held through END, then oe drops.
- After END the FSM returns to IDLE. Requests are ignored in END, so a master that deasserts after seeing done is never double-served.
- data_o keeps its last value until the next read completes. Writes do not alter data_o.
- ea_b_o is a 2-flop synchronizer of bus_ctrl_ea_b_pin_i.
- p2_o holds the last address in IDLE, as on the 8051.

## Timing
- Reset values (asynchronous, effective immediately even mid-cycle):
  - ale=0, psen_b=1, rd_b=1, wr_b=1, p0_oe=0, p0_o=8'hFF, p2_o=8'hFF.
  - data_o=8'h00, done=0, busy=0, ea_b_o=1, state IDLE, wait counter 0.
- Request sampled low at edge k gives ADDR in cycle k, LATCH in k+1, and STROBE in k+2 .. k+2+WAIT_STATES.
- END falls in cycle k+3+WAIT_STATES. Total access is 4+WAIT_STATES cycles.
- The next request can be accepted at edge k+5+WAIT_STATES at the earliest.
- A request that deasserts before IDLE samples it is ignored.
- A request that changes type during an access is ignored until IDLE.
- Simultaneous requests: only the highest-priority one is served. The others must be held by the master and are served in later cycles.
- Reset deasserting mid-access restarts in IDLE. No strobe glitch is permitted.

## Configuration
- BUS_CTRL_WAIT_PIN_EN defined:
  - Adds input port bus_ctrl_wait_b_i, active low.
  - While it is low in the final STROBE cycle, STROBE extends one cycle at a time. The stretch has no bound.
- BUS_CTRL_WAIT_PIN_EN undefined:
  - The port is absent.
  - STROBE length is exactly 1+WAIT_STATES.

## Structure
- Shared core definitions package holds:
  - state encodings: IDLE=3'd0, ADDR=3'd1, LATCH=3'd2, STROBE=3'd3, END=3'd4;
  - access-type codes: ROM, RAM_RD, RAM_WR;
  - the P0 idle value 8'hFF.
- One sub-module, core_bus_ctrl_sync, is the 2-flop EA_b synchronizer.
- FSM, wait counter and pin registers stay in core_bus_ctrl.

## Test plan
- Reset, then ROM read of 16'h1234 with p0_i=8'hA5 and WAIT_STATES=0:
  - ALE high 1 cycle with p0_o=8'h34 and p2_o=8'h12;
  - psen_b low 1 cycle;
  - done at cycle 3 with data_o=8'hA5; rd_b and wr_b stay 1.
- RAM write of 8'h5A to 16'h00F0:
  - p0_o=8'hF0 then 8'h5A, oe=1 through END;
  - wr_b low 1 cycle, rd_b and psen_b stay 1.
- WAIT_STATES=3, RAM read: rd_b low exactly 4 cycles and done at cycle 6.
- ROM and RAM-write requests low together: the ROM cycle runs first, then the write after done.
- Reset asserted during STROBE: all strobes high, oe=0 and ale=0 in the same cycle; a new request after release proceeds normally.
- EA_b pin toggles 1→0: ea_b_o follows 2 edges later.
- With BUS_CTRL_WAIT_PIN_EN, wait_b held low 5 cycles during STROBE: the strobe is stretched by 5 cycles.

Source files
------------

// File: rtl/core_bus_ctrl_pkg.sv
// Shared definitions for the EMC08 external bus controller: FSM state codes,
// access-type codes, P0 idle value and request priority.
package core_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_LATCH  = 3'd2,
    ST_STROBE = 3'd3,
    ST_END    = 3'd4
  } bus_state_e;

  typedef enum logic [1:0] {
    ACC_ROM    = 2'd0,
    ACC_RAM_RD = 2'd1,
    ACC_RAM_WR = 2'd2
  } acc_type_e;

  localparam logic [7:0] P0_IDLE  = 8'hFF;
  localparam logic       EA_RESET = 1'b1;

  // ROM read wins over RAM write, which wins over RAM read.
  function automatic acc_type_e pick_access(input logic rom_rd_b, input logic ram_wr_b);
    if (!rom_rd_b)      return ACC_ROM;
    else if (!ram_wr_b) return ACC_RAM_WR;
    else                return ACC_RAM_RD;
  endfunction

endpackage

// File: rtl/core_bus_ctrl_sync.sv
// Two-flop synchronizer for the asynchronous EA_b pin.
module core_bus_ctrl_sync
  import core_bus_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_b_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      meta_q <= EA_RESET;
      sync_q <= EA_RESET;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/core_bus_ctrl.sv
// Multiplexed 8051-style external bus controller (ALE/PSEN_b/RD_b/WR_b, P0/P2).
// Optional BUS_CTRL_WAIT_PIN_EN adds bus_ctrl_wait_b_i to stretch STROBE.
module core_bus_ctrl
  import core_bus_ctrl_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic        bus_ctrl_clk_i,
  input  logic        bus_ctrl_rst_b_i,
  input  logic        bus_ctrl_ext_rom_rd_b_i,
  input  logic        bus_ctrl_ext_ram_rd_b_i,
  input  logic        bus_ctrl_ext_ram_wr_b_i,
  input  logic [15:0] bus_ctrl_addr_i,
  input  logic [7:0]  bus_ctrl_data_i,
  output logic [7:0]  bus_ctrl_data_o,
  output logic        bus_ctrl_done_o,
  output logic        bus_ctrl_busy_o,
  input  logic        bus_ctrl_ea_b_pin_i,
  output logic        bus_ctrl_ea_b_o,
  output logic        bus_ctrl_ale_o,
  output logic        bus_ctrl_psen_b_o,
  output logic        bus_ctrl_rd_b_o,
  output logic        bus_ctrl_wr_b_o,
  output logic [7:0]  bus_ctrl_p0_o,
  input  logic [7:0]  bus_ctrl_p0_i,
  output logic        bus_ctrl_p0_oe_o,
  output logic [7:0]  bus_ctrl_p2_o,
`ifdef BUS_CTRL_WAIT_PIN_EN
  input  logic        bus_ctrl_wait_b_i,
`endif
  output logic [2:0]  bus_ctrl_state_o
);

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES);

  bus_state_e state_q, state_d;
  acc_type_e  type_q, type_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  p0_q, p0_d, p2_q, p2_d;
  logic        ale_q, ale_d, psen_b_q, psen_b_d, rd_b_q, rd_b_d, wr_b_q, wr_b_d;
  logic        oe_q, oe_d, done_q, done_d, busy_q, busy_d;
  logic        req_any, wait_ok;

  assign req_any = !(bus_ctrl_ext_rom_rd_b_i && bus_ctrl_ext_ram_rd_b_i && bus_ctrl_ext_ram_wr_b_i);

`ifdef BUS_CTRL_WAIT_PIN_EN
  assign wait_ok = bus_ctrl_wait_b_i;
`else
  assign wait_ok = 1'b1;
`endif

  always_ff @(posedge bus_ctrl_clk_i or negedge bus_ctrl_rst_b_i) begin
    if (!bus_ctrl_rst_b_i) begin
      state_q <= ST_IDLE;
      type_q  <= ACC_ROM;
      cnt_q   <= 3'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: if (req_any) begin
        state_d = ST_ADDR;
        type_d  = pick_access(bus_ctrl_ext_rom_rd_b_i, bus_ctrl_ext_ram_wr_b_i);
        addr_d  = bus_ctrl_addr_i;
        wdata_d = bus_ctrl_data_i;
      end
      ST_ADDR:  state_d = ST_LATCH;
      ST_LATCH: begin
        state_d = ST_STROBE;
        cnt_d   = 3'd0;
      end
      ST_STROBE: begin
        // The external wait pin only holds the last strobe cycle.
        if (cnt_q != WAIT_LAST) begin
          cnt_d = cnt_q + 3'd1;
        end else if (wait_ok) begin
          state_d = ST_END;
          cnt_d   = 3'd0;
        end
      end
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin values are derived from the next state so the registered pins line up
  // with the cycle in which the FSM occupies that state.
  always_comb begin
    ale_d    = (state_d == ST_ADDR);
    psen_b_d = !(state_d == ST_STROBE && type_d == ACC_ROM);
    rd_b_d   = !(state_d == ST_STROBE && type_d == ACC_RAM_RD);
    wr_b_d   = !(state_d == ST_STROBE && type_d == ACC_RAM_WR);
    done_d   = (state_d == ST_END);
    busy_d   = (state_d != ST_IDLE);
    p2_d     = (state_d == ST_ADDR) ? addr_d[15:8] : p2_q;
    p0_d     = P0_IDLE;
    oe_d     = 1'b0;
    case (state_d)
      ST_ADDR: begin
        p0_d = addr_d[7:0];
        oe_d = 1'b1;
      end
      ST_LATCH, ST_STROBE, ST_END: if (type_d == ACC_RAM_WR) begin
        p0_d = wdata_d;
        oe_d = 1'b1;
      end
      default: ;
    endcase
    rdata_d = rdata_q;
    if (state_q == ST_STROBE && state_d == ST_END && type_q != ACC_RAM_WR) begin
      rdata_d = bus_ctrl_p0_i;
    end
  end

  always_ff @(posedge bus_ctrl_clk_i or negedge bus_ctrl_rst_b_i) begin
    if (!bus_ctrl_rst_b_i) begin
      ale_q    <= 1'b0;
      psen_b_q <= 1'b1;
      rd_b_q   <= 1'b1;
      wr_b_q   <= 1'b1;
      oe_q     <= 1'b0;
      p0_q     <= P0_IDLE;
      p2_q     <= P0_IDLE;
      rdata_q  <= 8'h00;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ale_q    <= ale_d;
      psen_b_q <= psen_b_d;
      rd_b_q   <= rd_b_d;
      wr_b_q   <= wr_b_d;
      oe_q     <= oe_d;
      p0_q     <= p0_d;
      p2_q     <= p2_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  core_bus_ctrl_sync u_ea_sync (
    .clk_i   (bus_ctrl_clk_i),
    .rst_b_i (bus_ctrl_rst_b_i),
    .d_i     (bus_ctrl_ea_b_pin_i),
    .q_o     (bus_ctrl_ea_b_o)
  );

  assign bus_ctrl_ale_o    = ale_q;
  assign bus_ctrl_psen_b_o = psen_b_q;
  assign bus_ctrl_rd_b_o   = rd_b_q;
  assign bus_ctrl_wr_b_o   = wr_b_q;
  assign bus_ctrl_p0_oe_o  = oe_q;
  assign bus_ctrl_p0_o     = p0_q;
  assign bus_ctrl_p2_o     = p2_q;
  assign bus_ctrl_data_o   = rdata_q;
  assign bus_ctrl_done_o   = done_q;
  assign bus_ctrl_busy_o   = busy_q;
  assign bus_ctrl_state_o  = state_q;

endmodule

// File: tb/tb_core_bus_ctrl.sv
// Testbench for core_bus_ctrl: two instances (WAIT_STATES 0 and 3) share stimulus
// and are checked cycle by cycle against a timing model of the bus cycle.
module tb_core_bus_ctrl;

  localparam logic [1:0] K_ROM = 2'd0;
  localparam logic [1:0] K_RD  = 2'd1;
  localparam logic [1:0] K_WR  = 2'd2;

  typedef struct packed {
    logic       ale;
    logic       psen_b;
    logic       rd_b;
    logic       wr_b;
    logic       oe;
    logic [7:0] p0;
    logic [7:0] p2;
    logic       done;
    logic       busy;
    logic [7:0] data;
  } pins_t;

  localparam int PW = $bits(pins_t);

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  p0v;
    logic [7:0]  exp_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rom_b = 1'b1, rd_b = 1'b1, wr_b = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdat = 8'h00;
  logic [7:0]  p0_in = 8'h00;
  logic        ea_pin = 1'b1;
`ifdef BUS_CTRL_WAIT_PIN_EN
  logic        wait_b = 1'b1;
`endif

  logic [7:0] d0_data, d3_data, d0_p0, d3_p0, d0_p2, d3_p2;
  logic       d0_done, d3_done, d0_busy, d3_busy, d0_ea, d3_ea, d0_ale, d3_ale;
  logic       d0_psen, d3_psen, d0_rd, d3_rd, d0_wr, d3_wr, d0_oe, d3_oe;
  logic [2:0] d0_st, d3_st;
  pins_t      act0, act3;

  logic [PW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] last_rd = 8'h00;

  always #5 clk = ~clk;

  core_bus_ctrl #(.WAIT_STATES(0)) dut0 (
    .bus_ctrl_clk_i(clk), .bus_ctrl_rst_b_i(rst_n),
    .bus_ctrl_ext_rom_rd_b_i(rom_b), .bus_ctrl_ext_ram_rd_b_i(rd_b), .bus_ctrl_ext_ram_wr_b_i(wr_b),
    .bus_ctrl_addr_i(addr), .bus_ctrl_data_i(wdat), .bus_ctrl_data_o(d0_data),
    .bus_ctrl_done_o(d0_done), .bus_ctrl_busy_o(d0_busy),
    .bus_ctrl_ea_b_pin_i(ea_pin), .bus_ctrl_ea_b_o(d0_ea), .bus_ctrl_ale_o(d0_ale),
    .bus_ctrl_psen_b_o(d0_psen), .bus_ctrl_rd_b_o(d0_rd), .bus_ctrl_wr_b_o(d0_wr),
    .bus_ctrl_p0_o(d0_p0), .bus_ctrl_p0_i(p0_in), .bus_ctrl_p0_oe_o(d0_oe), .bus_ctrl_p2_o(d0_p2),
`ifdef BUS_CTRL_WAIT_PIN_EN
    .bus_ctrl_wait_b_i(wait_b),
`endif
    .bus_ctrl_state_o(d0_st)
  );

  core_bus_ctrl #(.WAIT_STATES(3)) dut3 (
    .bus_ctrl_clk_i(clk), .bus_ctrl_rst_b_i(rst_n),
    .bus_ctrl_ext_rom_rd_b_i(rom_b), .bus_ctrl_ext_ram_rd_b_i(rd_b), .bus_ctrl_ext_ram_wr_b_i(wr_b),
    .bus_ctrl_addr_i(addr), .bus_ctrl_data_i(wdat), .bus_ctrl_data_o(d3_data),
    .bus_ctrl_done_o(d3_done), .bus_ctrl_busy_o(d3_busy),
    .bus_ctrl_ea_b_pin_i(ea_pin), .bus_ctrl_ea_b_o(d3_ea), .bus_ctrl_ale_o(d3_ale),
    .bus_ctrl_psen_b_o(d3_psen), .bus_ctrl_rd_b_o(d3_rd), .bus_ctrl_wr_b_o(d3_wr),
    .bus_ctrl_p0_o(d3_p0), .bus_ctrl_p0_i(p0_in), .bus_ctrl_p0_oe_o(d3_oe), .bus_ctrl_p2_o(d3_p2),
`ifdef BUS_CTRL_WAIT_PIN_EN
    .bus_ctrl_wait_b_i(wait_b),
`endif
    .bus_ctrl_state_o(d3_st)
  );

  // P0 only matters while it is driven.
  assign act0 = {d0_ale, d0_psen, d0_rd, d0_wr, d0_oe, d0_oe ? d0_p0 : 8'h00, d0_p2, d0_done, d0_busy, d0_data};
  assign act3 = {d3_ale, d3_psen, d3_rd, d3_wr, d3_oe, d3_oe ? d3_p0 : 8'h00, d3_p2, d3_done, d3_busy, d3_data};

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, act, exp);
    end
  endtask

  function automatic pins_t reset_pins();
    pins_t p;
    p = '0;
    p.psen_b = 1'b1;
    p.rd_b   = 1'b1;
    p.wr_b   = 1'b1;
    p.p2     = 8'hFF;
    return p;
  endfunction

  // Pin picture c cycles after the request was taken: ADDR, LATCH, 1+ws STROBE, END, IDLE.
  function automatic pins_t model(input int ws, input int c, input logic [1:0] kind,
                                  input logic [15:0] a, input logic [7:0] wd, input logic [7:0] dn);
    pins_t p;
    p.ale    = (c == 0);
    p.psen_b = !(kind == K_ROM && c >= 2 && c <= 2 + ws);
    p.rd_b   = !(kind == K_RD  && c >= 2 && c <= 2 + ws);
    p.wr_b   = !(kind == K_WR  && c >= 2 && c <= 2 + ws);
    p.oe     = (c == 0) || (kind == K_WR && c <= 3 + ws);
    p.p0     = (c == 0) ? a[7:0] : (p.oe ? wd : 8'h00);
    p.p2     = a[15:8];
    p.done   = (c == 3 + ws);
    p.busy   = (c <= 3 + ws);
    p.data   = dn;
    return p;
  endfunction

  task automatic set_req(input logic [1:0] kind, input logic on);
    rom_b = !(on && kind == K_ROM);
    rd_b  = !(on && kind == K_RD);
    wr_b  = !(on && kind == K_WR);
  endtask

  task automatic run_access(input logic [1:0] kind, input logic [15:0] a,
                            input logic [7:0] wd, input logic [7:0] p0v);
    logic [7:0] dn;
    int ws;
    logic [PW-1:0] e;
    for (int c = 0; c < 8; c++) begin
      for (int d = 0; d < 2; d++) begin
        ws = (d == 0) ? 0 : 3;
        dn = (kind != K_WR && c >= 3 + ws) ? p0v : last_rd;
        exp_q.push_back(model(ws, c, kind, a, wd, dn));
      end
    end
    @(negedge clk);
    set_req(kind, 1'b1);
    addr  = a;
    wdat  = wd;
    p0_in = p0v;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        set_req(kind, 1'b0);
        addr = ~a;
        wdat = ~wd;
        check("state_addr", c, 32'({d0_st, d3_st}), 32'({3'd1, 3'd1}));
      end
      if (c == 6) p0_in = ~p0v;
      e = exp_q.pop_front();
      check("acc_ws0", c, 32'(act0), 32'(e));
      e = exp_q.pop_front();
      check("acc_ws3", c, 32'(act3), 32'(e));
    end
    if (kind != K_WR) last_rd = p0v;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!d0_busy && !d3_busy) break;
    end
    check("idle_wait", 0, 32'({d0_busy, d3_busy}), 32'(0));
    @(negedge clk);
  endtask

  vec_t tbl[6];

  initial begin
    int ndone, first_done, second_done, psen_cnt, wr_cnt, psen_last, first_wr, rd_low, done_at;
    logic [7:0] wr_p0;

    tbl[0] = '{K_ROM, 16'h1234, 8'h00, 8'hA5, 8'hA5};
    tbl[1] = '{K_WR,  16'h00F0, 8'h5A, 8'hC3, 8'hA5};
    tbl[2] = '{K_RD,  16'hBEEF, 8'h11, 8'h96, 8'h96};
    tbl[3] = '{K_ROM, 16'hFFFF, 8'h00, 8'h00, 8'h00};
    tbl[4] = '{K_WR,  16'h0000, 8'hFF, 8'h5A, 8'h00};
    tbl[5] = '{K_RD,  16'h8001, 8'h00, 8'hFF, 8'hFF};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_pins_ws0", 0, 32'(act0), 32'(reset_pins()));
    check("rst_pins_ws3", 0, 32'(act3), 32'(reset_pins()));
    check("rst_p0_raw", 0, 32'({d0_p0, d3_p0}), 32'(16'hFFFF));
    check("rst_state", 0, 32'({d0_st, d3_st}), 32'(0));
    check("rst_ea", 0, 32'({d0_ea, d3_ea}), 32'(2'b11));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run_access(tbl[i].kind, tbl[i].addr, tbl[i].wdata, tbl[i].p0v);
      check("tbl_data", i, 32'({d0_data, d3_data}), 32'({tbl[i].exp_data, tbl[i].exp_data}));
    end

    // Random accesses.
    for (int i = 0; i < 30; i++) begin
      run_access(2'($urandom_range(0, 2)), 16'($urandom), 8'($urandom), 8'($urandom));
    end

    // ROM read and RAM write requested together; master holds each until its done.
    @(negedge clk);
    rom_b = 1'b0; wr_b = 1'b0; addr = 16'h4321; wdat = 8'h77; p0_in = 8'h3C;
    ndone = 0; first_done = -1; second_done = -1; psen_cnt = 0; wr_cnt = 0;
    psen_last = -1; first_wr = -1; wr_p0 = 8'h00;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!d0_psen) begin psen_cnt++; psen_last = c; end
      if (!d0_wr) begin
        wr_cnt++;
        if (first_wr < 0) first_wr = c;
        wr_p0 = d0_p0;
      end
      if (d0_done) begin
        ndone++;
        if (ndone == 1) begin first_done = c; rom_b = 1'b1; end
        else begin second_done = c; wr_b = 1'b1; end
      end
    end
    rom_b = 1'b1; wr_b = 1'b1;
    check("prio_psen_cnt", 0, 32'(psen_cnt), 32'(1));
    check("prio_wr_cnt", 0, 32'(wr_cnt), 32'(1));
    check("prio_psen_at", 0, 32'(psen_last), 32'(2));
    check("prio_wr_at", 0, 32'(first_wr), 32'(7));
    check("prio_done1", 0, 32'(first_done), 32'(3));
    check("prio_done2", 0, 32'(second_done), 32'(8));
    check("prio_ndone", 0, 32'(ndone), 32'(2));
    check("prio_wr_data", 0, 32'(wr_p0), 32'(8'h77));
    check("prio_rd_data", 0, 32'(d0_data), 32'(8'h3C));
    wait_idle();
    check("prio_rd_data3", 0, 32'(d3_data), 32'(8'h3C));
    last_rd = 8'h3C;

    // Reset asserted while the strobe is low.
    @(negedge clk);
    rd_b = 1'b0; addr = 16'h2222; p0_in = 8'h99;
    @(negedge clk);
    rd_b = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_rst_strobe", 0, 32'({d0_rd, d3_rd}), 32'(2'b00));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ws0", 0, 32'(act0), 32'({reset_pins()}));
    check("mid_rst_ws3", 0, 32'(act3), 32'({reset_pins()}));
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = 8'h00;
    run_access(K_ROM, 16'h5AA5, 8'h00, 8'h42);

    // EA_b synchronizer latency.
    @(negedge clk);
    ea_pin = 1'b0;
    @(negedge clk);
    check("ea_1edge", 0, 32'({d0_ea, d3_ea}), 32'(2'b11));
    @(negedge clk);
    check("ea_2edge", 0, 32'({d0_ea, d3_ea}), 32'(2'b00));
    ea_pin = 1'b1;
    repeat (2) @(negedge clk);
    check("ea_back", 0, 32'({d0_ea, d3_ea}), 32'(2'b11));

`ifdef BUS_CTRL_WAIT_PIN_EN
    // Wait pin low for five final-strobe cycles stretches RD_b by five.
    @(negedge clk);
    rd_b = 1'b0; wait_b = 1'b0; addr = 16'h0505; p0_in = 8'h6D;
    rd_low = 0; done_at = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) rd_b = 1'b1;
      if (c == 7) wait_b = 1'b1;
      if (!d0_rd) rd_low++;
      if (d0_done && done_at < 0) done_at = c;
    end
    wait_b = 1'b1;
    check("wait_rd_low", 0, 32'(rd_low), 32'(6));
    check("wait_done_at", 0, 32'(done_at), 32'(8));
    check("wait_data", 0, 32'(d0_data), 32'(8'h6D));
    wait_idle();
    last_rd = 8'h6D;
`else
    rd_low = 0; done_at = 0;
`endif

    run_access(K_RD, 16'hC0DE, 8'h00, 8'hE7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
